// File: rtl/work_scheduler_pkg.sv
// Shared types and constants for the work scheduler.
// Types, nonce field position and chunk-count helper.
package work_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DISPATCH,
    S_DRAIN
  } state_e;

  localparam int NONCE_W   = 32;
  localparam int NONCE_MSB = 639;
  localparam int NONCE_LSB = 608;

  function automatic logic [NONCE_W-1:0] chunk_count(input int log2);
    return NONCE_W'(1) << (NONCE_W - log2);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-set finder.
// Searches req upward from ptr with wrap; one-hot grant plus index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    logic [IW-1:0] j;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/work_scheduler.sv
// Nonce-chunk dispatcher and found-nonce collector for a hash core bank.
// SCHED_STATS_EN adds stat_chunks / stat_results counters.
module work_scheduler
  import work_scheduler_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int CHUNK_LOG2 = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         work_restart,
  input  logic                         new_work,
  input  logic [639:0]                 work_data,
  output logic                         got_work,
  output logic [NUM_CORES-1:0]         core_start,
  output logic [NONCE_W-1:0]           core_nonce_base,
  input  logic [NUM_CORES-1:0]         core_busy,
  input  logic [NUM_CORES-1:0]         core_found,
  input  logic [NUM_CORES*NONCE_W-1:0] core_found_nonce,
  output logic [NUM_CORES-1:0]         core_ack,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [NONCE_W-1:0]           result_data,
  output logic                         exhausted
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]                  stat_chunks,
  output logic [31:0]                  stat_results
`endif
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [NONCE_W-1:0] CHUNK = NONCE_W'(1) << CHUNK_LOG2;
  localparam logic [NONCE_W-1:0] TOTAL = chunk_count(CHUNK_LOG2);

  typedef logic [NUM_CORES-1:0] vec_t;

  state_e       state_q, state_d;
  logic [31:0]  start_q, start_d;
  logic [31:0]  nonce_q, nonce_d;
  logic [31:0]  issued_q, issued_d;
  logic [IW-1:0] dp_q, dp_d, ap_q, ap_d;
  vec_t         mask_a_q, mask_a_d, mask_b_q, mask_b_d;
  logic         got_q, got_d, exh_q, exh_d;
  vec_t         cs_q, cs_d;
  logic [31:0]  base_q, base_d;
  logic         rv_q, rv_d;
  logic [31:0]  rd_q, rd_d;

  vec_t          d_gnt, a_gnt;
  logic [IW-1:0] d_idx, a_idx;
  logic          d_vld, a_vld, load;
  logic          unused_work;

  assign unused_work = ^work_data[NONCE_LSB-1:0];

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NUM_CORES - 1)) ? '0 : i + 1'b1;
  endfunction

  // A started core is masked until its busy flag is visible.
  rr_pick #(.N(NUM_CORES), .IW(IW)) u_dpick (
    .req   (~core_busy & ~(mask_a_q | mask_b_q)),
    .ptr   (dp_q),
    .gnt   (d_gnt),
    .idx   (d_idx),
    .valid (d_vld)
  );

  rr_pick #(.N(NUM_CORES), .IW(IW)) u_apick (
    .req   (core_found),
    .ptr   (ap_q),
    .gnt   (a_gnt),
    .idx   (a_idx),
    .valid (a_vld)
  );

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    nonce_d  = nonce_q;
    issued_d = issued_q;
    dp_d     = dp_q;
    mask_a_d = '0;
    mask_b_d = mask_a_q;
    got_d    = 1'b0;
    cs_d     = '0;
    base_d   = base_q;
    exh_d    = 1'b0;
    if (work_restart) begin
      state_d  = S_IDLE;
      issued_d = '0;
      mask_b_d = '0;
    end else if (new_work) begin
      state_d  = S_LOAD;
      start_d  = work_data[NONCE_MSB:NONCE_LSB] & ~(CHUNK - 1'b1);
      got_d    = 1'b1;
      issued_d = '0;
      mask_b_d = '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          nonce_d  = start_q;
          issued_d = '0;
          state_d  = S_DISPATCH;
        end
        S_DISPATCH: begin
          if (d_vld) begin
            cs_d     = d_gnt;
            base_d   = nonce_q;
            nonce_d  = nonce_q + CHUNK;
            issued_d = issued_q + 1'b1;
            dp_d     = next_idx(d_idx);
            mask_a_d = d_gnt;
            if (issued_q + 1'b1 == TOTAL) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (core_busy == '0 && core_found == '0 && !rv_q &&
              (mask_a_q | mask_b_q) == '0) begin
            exh_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Register refills in the same cycle it drains.
  always_comb begin
    rv_d = rv_q && !result_ready;
    rd_d = rd_q;
    ap_d = ap_q;
    load = !rv_d && a_vld;
    if (load) begin
      rv_d = 1'b1;
      ap_d = next_idx(a_idx);
      for (int i = 0; i < NUM_CORES; i++)
        if (a_gnt[i]) rd_d = core_found_nonce[i*NONCE_W +: NONCE_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      start_q  <= '0;
      nonce_q  <= '0;
      issued_q <= '0;
      dp_q     <= '0;
      ap_q     <= '0;
      mask_a_q <= '0;
      mask_b_q <= '0;
      got_q    <= 1'b0;
      cs_q     <= '0;
      base_q   <= '0;
      exh_q    <= 1'b0;
      rv_q     <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      nonce_q  <= nonce_d;
      issued_q <= issued_d;
      dp_q     <= dp_d;
      ap_q     <= ap_d;
      mask_a_q <= mask_a_d;
      mask_b_q <= mask_b_d;
      got_q    <= got_d;
      cs_q     <= cs_d;
      base_q   <= base_d;
      exh_q    <= exh_d;
      rv_q     <= rv_d;
      rd_q     <= rd_d;
    end
  end

  assign got_work        = got_q;
  assign core_start      = cs_q;
  assign core_nonce_base = base_q;
  assign exhausted       = exh_q;
  assign result_valid    = rv_q;
  assign result_data     = rd_q;
  assign core_ack        = (load && rst) ? a_gnt : '0;

`ifdef SCHED_STATS_EN
  logic [31:0] chunks_q, chunks_d, results_q, results_d;

  always_comb begin
    chunks_d  = chunks_q;
    results_d = results_q;
    if (got_d) chunks_d = '0;
    else if (|cs_d && chunks_q != '1) chunks_d = chunks_q + 1'b1;
    if (rv_q && result_ready && results_q != '1)
      results_d = results_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chunks_q  <= '0;
      results_q <= '0;
    end else begin
      chunks_q  <= chunks_d;
      results_q <= results_d;
    end
  end

  assign stat_chunks  = chunks_q;
  assign stat_results = results_q;
`endif

endmodule

// File: tb/tb_work_scheduler.sv
// Directed bench for work_scheduler with start/result scoreboards.
// Build with SCHED_STATS_EN to also check the statistics ports.
module tb_work_scheduler;

  localparam int NC       = 4;
  localparam int CL       = 30;
  localparam int BUSY_LEN = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            work_restart = 1'b0;
  logic            new_work = 1'b0;
  logic [639:0]    work_data = '0;
  logic            got_work;
  logic [NC-1:0]   core_start;
  logic [31:0]     core_nonce_base;
  logic [NC-1:0]   core_busy;
  logic [NC-1:0]   core_found = '0;
  logic [NC*32-1:0] core_found_nonce = '0;
  logic [NC-1:0]   core_ack;
  logic            result_valid;
  logic            result_ready = 1'b0;
  logic [31:0]     result_data;
  logic            exhausted;
`ifdef SCHED_STATS_EN
  logic [31:0]     stat_chunks, stat_results;
`endif

  typedef struct {
    logic [NC-1:0] onehot;
    logic [31:0]   base;
  } start_t;

  start_t      sq[$];
  logic [31:0] rq[$];
  logic [NC-1:0] fset = '0;
  int bcnt[NC] = '{default: 0};
  int checks = 0, errors = 0;
  int gw_cnt = 0, exh_cnt = 0, ack_cnt = 0;

  work_scheduler #(.NUM_CORES(NC), .CHUNK_LOG2(CL)) dut (
    .clk              (clk),
    .rst              (rst),
    .work_restart     (work_restart),
    .new_work         (new_work),
    .work_data        (work_data),
    .got_work         (got_work),
    .core_start       (core_start),
    .core_nonce_base  (core_nonce_base),
    .core_busy        (core_busy),
    .core_found       (core_found),
    .core_found_nonce (core_found_nonce),
    .core_ack         (core_ack),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_data      (result_data),
    .exhausted        (exhausted)
`ifdef SCHED_STATS_EN
    ,
    .stat_chunks      (stat_chunks),
    .stat_results     (stat_results)
`endif
  );

  always #5 clk = ~clk;

  // Core bank model: busy for BUSY_LEN cycles after a start strobe.
  always @(posedge clk)
    for (int i = 0; i < NC; i++)
      if (core_start[i]) bcnt[i] <= BUSY_LEN;
      else if (bcnt[i] != 0) bcnt[i] <= bcnt[i] - 1;

  always_comb begin
    core_busy = '0;
    for (int i = 0; i < NC; i++) core_busy[i] = (bcnt[i] != 0);
  end

  // Found flags hold until acknowledged.
  always @(posedge clk)
    core_found <= (core_found & ~core_ack) | fset;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    start_t e;
    if (rst) begin
      chk("ack_onehot0", 64'($onehot0(core_ack)), 64'd1);
      if (|core_ack) ack_cnt++;
      if (got_work) gw_cnt++;
      if (exhausted) exh_cnt++;
      if (|core_start) begin
        if (sq.size() == 0) chk("unexpected_start", 64'(core_start), 64'd0);
        else begin
          e = sq.pop_front();
          chk("start_core", 64'(core_start), 64'(e.onehot));
          chk("start_base", 64'(core_nonce_base), 64'(e.base));
        end
      end
      if (result_valid && result_ready) begin
        if (rq.size() == 0) chk("unexpected_result", 64'(result_valid), 64'd0);
        else chk("result_data", 64'(result_data), 64'(rq.pop_front()));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_got_work"}, 64'(got_work), 64'd0);
    chk({tag, "_core_start"}, 64'(core_start), 64'd0);
    chk({tag, "_base"}, 64'(core_nonce_base), 64'd0);
    chk({tag, "_ack"}, 64'(core_ack), 64'd0);
    chk({tag, "_rvalid"}, 64'(result_valid), 64'd0);
    chk({tag, "_rdata"}, 64'(result_data), 64'd0);
    chk({tag, "_exhausted"}, 64'(exhausted), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    step;
    rst = 1'b1;
    step;
    step;

    // Full dispatch with wrap of the chunk base, then drain.
    sq.push_back('{4'b0001, 32'h4000_0000});
    sq.push_back('{4'b0010, 32'h8000_0000});
    sq.push_back('{4'b0100, 32'hC000_0000});
    sq.push_back('{4'b1000, 32'h0000_0000});
    work_data[639:608] = 32'h7FFF_FFFF;
    new_work = 1'b1;
    step;
    new_work = 1'b0;
    @(negedge clk);
    chk("got_work_pulse", 64'(got_work), 64'd1);
    for (int i = 0; i < 60 && exh_cnt == 0; i++) step;
    repeat (5) step;
    chk("exhausted_once", 64'(exh_cnt), 64'd1);
    chk("starts_done", 64'(sq.size()), 64'd0);
    chk("got_work_once", 64'(gw_cnt), 64'd1);

    // Two simultaneous founds, round-robin order and pointer wrap.
    result_ready = 1'b1;
    core_found_nonce[63:32]  = 32'hAAAA_0001;
    core_found_nonce[127:96] = 32'hBBBB_0003;
    rq.push_back(32'hAAAA_0001);
    rq.push_back(32'hBBBB_0003);
    fset = 4'b1010;
    step;
    fset = '0;
    for (int i = 0; i < 20 && rq.size() != 0; i++) step;
    chk("results_1_3", 64'(rq.size()), 64'd0);
    core_found_nonce[31:0]  = 32'h0000_C0DE;
    core_found_nonce[95:64] = 32'h0000_2222;
    rq.push_back(32'h0000_C0DE);
    rq.push_back(32'h0000_2222);
    fset = 4'b0101;
    step;
    fset = '0;
    for (int i = 0; i < 20 && rq.size() != 0; i++) step;
    chk("results_0_2", 64'(rq.size()), 64'd0);
    chk("ack_count_4", 64'(ack_cnt), 64'd4);

    // Backpressure: data held, no acks while full.
    result_ready = 1'b0;
    core_found_nonce[63:32] = 32'h1111_0001;
    core_found_nonce[95:64] = 32'h2222_0002;
    fset = 4'b0110;
    step;
    fset = '0;
    step;
    step;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(result_valid), 64'd1);
      chk("hold_data", 64'(result_data), 64'h1111_0001);
      chk("hold_no_ack", 64'(core_ack), 64'd0);
      step;
    end
    rq.push_back(32'h1111_0001);
    rq.push_back(32'h2222_0002);
    result_ready = 1'b1;
    for (int i = 0; i < 20 && rq.size() != 0; i++) step;
    chk("bp_results", 64'(rq.size()), 64'd0);
    chk("ack_count_6", 64'(ack_cnt), 64'd6);

    // Restart with same-cycle new_work mid-dispatch.
    result_ready = 1'b0;
    core_found_nonce[31:0] = 32'h1234_5678;
    rq.push_back(32'h1234_5678);
    fset = 4'b0001;
    step;
    fset = '0;
    for (int i = 0; i < 10 && !result_valid; i++) step;
    chk("pending_valid", 64'(result_valid), 64'd1);
    sq.push_back('{4'b0001, 32'h0000_0000});
    sq.push_back('{4'b0010, 32'h4000_0000});
    work_data[639:608] = 32'h0000_0005;
    new_work = 1'b1;
    step;
    new_work = 1'b0;
    step;
    step;
    step;
    work_restart = 1'b1;
    new_work = 1'b1;
    step;
    work_restart = 1'b0;
    new_work = 1'b0;
    repeat (10) step;
    chk("restart_no_got_work", 64'(gw_cnt), 64'd2);
    chk("restart_starts", 64'(sq.size()), 64'd0);
    chk("restart_no_exh", 64'(exh_cnt), 64'd1);
    result_ready = 1'b1;
    for (int i = 0; i < 20 && rq.size() != 0; i++) step;
    chk("restart_result", 64'(rq.size()), 64'd0);

    // Asynchronous reset between edges mid-dispatch.
    sq.push_back('{4'b0100, 32'h8000_0000});
    work_data[639:608] = 32'h8000_0001;
    new_work = 1'b1;
    step;
    new_work = 1'b0;
    step;
    step;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_starts", 64'(sq.size()), 64'd0);
    step;
    rst = 1'b1;
    repeat (10) step;
    chk("post_rst_idle_gw", 64'(gw_cnt), 64'd3);

    // Fresh run after reset with two results.
    sq.push_back('{4'b0001, 32'h0000_0000});
    sq.push_back('{4'b0010, 32'h4000_0000});
    sq.push_back('{4'b0100, 32'h8000_0000});
    sq.push_back('{4'b1000, 32'hC000_0000});
    core_found_nonce[63:32] = 32'h5151_0001;
    core_found_nonce[95:64] = 32'h6262_0002;
    work_data[639:608] = 32'h3FFF_FFFF;
    new_work = 1'b1;
    step;
    new_work = 1'b0;
    rq.push_back(32'h5151_0001);
    rq.push_back(32'h6262_0002);
    fset = 4'b0110;
    step;
    fset = '0;
    for (int i = 0; i < 80 && exh_cnt < 2; i++) step;
    repeat (3) step;
    chk("final_exhausted", 64'(exh_cnt), 64'd2);
    chk("final_starts", 64'(sq.size()), 64'd0);
    chk("final_results", 64'(rq.size()), 64'd0);
    chk("final_got_work", 64'(gw_cnt), 64'd4);
`ifdef SCHED_STATS_EN
    @(negedge clk);
    chk("stat_chunks", 64'(stat_chunks), 64'd4);
    chk("stat_results", 64'(stat_results), 64'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/work_scheduler.md
Name: work_scheduler

Overview:
- Sits between the serial work receiver and a bank of NUM_CORES hash cores.
- On new work, it splits the 32-bit nonce space into 2^CHUNK_LOG2-sized chunks and issues each chunk to the next idle core in round-robin order.
- It collects found-nonces from the cores through a round-robin arbiter and presents them as a valid/ready result stream.
- It reports exhaustion when the whole nonce space has been issued and all cores are idle.

Parameters:
- NUM_CORES, 4: number of hash cores (1..16).
- CHUNK_LOG2, 24: log2 of nonces per chunk (8..31).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- work_restart  in  1  abort current work and return to IDLE.
- new_work  in  1  one-cycle strobe; work_data is valid.
- work_data  in  640  block header; bits [639:608] are the starting nonce.
- got_work  out  1  one-cycle acknowledge of an accepted new_work.
- core_start  out  NUM_CORES  one-cycle start strobe per core.
- core_nonce_base  out  32  chunk base; valid in the core_start cycle.
- core_busy  in  NUM_CORES  core is hashing a chunk.
- core_found  in  NUM_CORES  core holds a found nonce; held until acknowledged.
- core_found_nonce  in  NUM_CORES*32  per-core found nonce; core i uses bits [32i+31:32i].
- core_ack  out  NUM_CORES  one-hot; found nonce consumed.
- result_valid  out  1  result_data is valid.
- result_ready  in  1  downstream accepts the result.
- result_data  out  32  found nonce.
- exhausted  out  1  one-cycle pulse when the nonce space is fully searched.

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, next_nonce=0, issued_cnt=0, rr pointers=0, result register empty.
- FSM states: IDLE, LOAD, DISPATCH, DRAIN.
  - IDLE: on new_work, capture start=work_data[639:608] with the low CHUNK_LOG2 bits cleared; pulse got_work the next cycle; go to LOAD.
  - LOAD: next_nonce=start, issued_cnt=0; go to DISPATCH.
  - DISPATCH: each cycle, at most one core starts. The core chosen is the first with core_busy=0, searching from dispatch pointer dp upward with wrap. Assert core_start[i] and core_nonce_base=next_nonce. Then next_nonce += 2^CHUNK_LOG2 (mod 2^32, wraps to 0), issued_cnt += 1, dp=i+1 mod NUM_CORES.
  - Before a core_start can issue to a core, that core must show busy; the scheduler therefore masks core i for 2 cycles after its start strobe.
  - When issued_cnt reaches 2^(32-CHUNK_LOG2), go to DRAIN.
  - DRAIN: when core_busy=0 and no core_found is pending and the result register is empty, pulse exhausted and go to IDLE.
- new_work in DISPATCH or DRAIN:
  - treated as work_restart followed by acceptance; got_work pulses;
  - cores are not aborted (the core bank flushes on its own restart);
  - in-flight results from old work are still forwarded.
- work_restart in any state: go to IDLE next cycle. Clear issued_cnt and the dispatch mask. The result register is kept. work_restart takes priority over a same-cycle new_work; that new_work is dropped and got_work is not pulsed.
- Result path:
  - 1-entry register. When empty, pick the first asserted core_found from arbiter pointer ap upward with wrap.
  - Load core_found_nonce of that core into result_data, pulse core_ack[i], set result_valid, ap=i+1.
  - result_valid && result_ready empties the register. A new load is allowed in the same cycle (full throughput: one result per cycle).
  - result_data is held stable while result_valid && !result_ready.
- A core_found arriving in the same cycle as a core_start to another core: both proceed independently.

Optional Feature:
- Macro SCHED_STATS_EN.
- When defined, adds outputs stat_chunks (32, chunks issued since the last new_work) and stat_results (32, results handed downstream since reset). Both saturate at all-ones; stat_chunks clears on accepted new_work.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE/LOAD/DISPATCH/DRAIN);
  - NONCE_W=32;
  - the nonce field position constants 639/608;
  - a function returning chunk count from CHUNK_LOG2.
- One sub-module, rr_pick: a parameterized round-robin first-set finder (req vector and pointer in, one-hot grant and index out). It is instantiated twice, for dispatch and for result arbitration.

Test Plan:
- NUM_CORES=4, CHUNK_LOG2=30, cores idle; new_work with nonce 0x7FFF_FFFF -> got_work 1 cycle later. Starts on cores 0,1,2,3 with bases 0x4000_0000, 0x8000_0000, 0xC000_0000, 0x0000_0000 (wrap). Then DRAIN; exhausted pulses once after all busy drop.
- Cores 1 and 3 assert core_found together (nonces 0xAAAA_0001, 0xBBBB_0003), result_ready=1 -> results in order 1 then 3. core_ack one-hot per cycle; ap ends at 0.
- result_ready held 0 for 5 cycles with result_valid=1 -> result_data stable; no core_ack issued while the register is full.
- work_restart asserted mid-DISPATCH together with new_work -> no got_work, FSM=IDLE, no further core_start, pending result still delivered.
- rst driven to 0 asynchronously mid-DISPATCH (between clock edges) -> all outputs 0 immediately. After release, a new_work is required before any core_start.
- SCHED_STATS_EN defined, CHUNK_LOG2=30, full run with 2 results -> stat_chunks=4, stat_results=2.
